// File: rtl/act_pkg.sv
// Shared types and helpers for the activation LUT scheduler.
// Holds function encodings, default widths and the LUT curve.
package act_pkg;

  localparam logic FUNC_SIGMOID = 1'b0;
  localparam logic FUNC_TANH    = 1'b1;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_FRACT_WIDTH = 5;

  function automatic int id_width(int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Piecewise-linear sigmoid for a non-negative magnitude, f frac bits.
  function automatic logic [15:0] plan_pos(
    logic [15:0] a,
    int f
  );
    logic [15:0] one;
    one = 16'd1 << f;
    if (a >= 16'd5 * one)
      return one;
    if (a >= (16'd19 * one) >> 3)
      return (a >> 5) + ((16'd27 * one) >> 5);
    if (a >= one)
      return (a >> 3) + ((16'd5 * one) >> 3);
    return (a >> 2) + (one >> 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after pointer.
// Index reports the winner even when enable masks the grant.
module rr_arbiter
  import act_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]             req,
  input  logic [id_width(NREQ)-1:0]   pointer,
  input  logic                        enable,
  output logic [NREQ-1:0]             grant,
  output logic [id_width(NREQ)-1:0]   index
);

  localparam int IDW = id_width(NREQ);

  logic hit;
  int   idx;

  always_comb begin
    grant = '0;
    index = '0;
    hit   = 1'b0;
    idx   = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(pointer) + off) % NREQ;
      if (!hit && req[idx]) begin
        hit   = 1'b1;
        index = IDW'(idx);
      end
    end
    if (enable && hit)
      grant[index] = 1'b1;
  end

endmodule

// File: rtl/sigmoid_lut.sv
// Combinational sigmoid table indexed by the raw signed operand.
// Negative inputs use the symmetry sigmoid(-x) = 1 - sigmoid(x).
module sigmoid_lut
  import act_pkg::*;
#(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int FRACT_WIDTH = 5
) (
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] data
);

  logic          neg;
  logic [AW-1:0] m;
  logic [15:0]   one;
  logic [15:0]   y;

  always_comb begin
    neg  = addr[AW-1];
    m    = neg ? (~addr + 1'b1) : addr;
    one  = 16'd1 << FRACT_WIDTH;
    y    = plan_pos(16'(m), FRACT_WIDTH);
    data = neg ? DW'(one - y) : DW'(y);
  end

endmodule

// File: rtl/tanh_lut.sv
// Combinational tanh table indexed by the raw signed operand.
// Built as tanh(x) = 2*sigmoid(2x) - 1, odd-symmetric.
module tanh_lut
  import act_pkg::*;
#(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int FRACT_WIDTH = 5
) (
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] data
);

  logic          neg;
  logic [AW-1:0] m;
  logic [15:0]   one;
  logic [15:0]   s;
  logic [15:0]   t;

  always_comb begin
    neg  = addr[AW-1];
    m    = neg ? (~addr + 1'b1) : addr;
    one  = 16'd1 << FRACT_WIDTH;
    s    = plan_pos(16'(m) << 1, FRACT_WIDTH);
    t    = (s << 1) - one;
    data = neg ? DW'(-t) : DW'(t);
  end

endmodule

// File: rtl/act_lut_scheduler.sv
// Shares one sigmoid and one tanh LUT among NREQ requesters with
// round-robin arbitration and a two-stage pipeline (S1 operand, S2 result).
module act_lut_scheduler
  import act_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int FRACT_WIDTH = DEF_FRACT_WIDTH,
  parameter int AW          = DATA_WIDTH,
  parameter int DW          = DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NREQ-1:0]              req_func,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_WIDTH-1:0]        rsp_data,
  output logic [id_width(NREQ)-1:0]    rsp_id
);

  localparam int IDW = id_width(NREQ);

  logic                  stall;
  logic                  s1_open;
  logic                  s1_valid;
  logic                  s1_func;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [IDW-1:0]        s1_id;
  logic [IDW-1:0]        ptr;
  logic [IDW-1:0]        gnt_idx;
  logic [NREQ-1:0]       gnt;
  logic                  xfer;
  logic [DW-1:0]         sig_y;
  logic [DW-1:0]         tanh_y;

  assign stall   = rsp_valid & ~rsp_ready;
  assign s1_open = ~s1_valid | ~stall;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req_valid),
    .pointer (ptr),
    .enable  (s1_open & ~rst),
    .grant   (gnt),
    .index   (gnt_idx)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;

  sigmoid_lut #(
    .AW(AW), .DW(DW), .FRACT_WIDTH(FRACT_WIDTH)
  ) u_sig (
    .addr (s1_data),
    .data (sig_y)
  );

  tanh_lut #(
    .AW(AW), .DW(DW), .FRACT_WIDTH(FRACT_WIDTH)
  ) u_tanh (
    .addr (s1_data),
    .data (tanh_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_func   <= FUNC_SIGMOID;
      s1_id     <= '0;
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      if (!stall) begin
        rsp_valid <= s1_valid;
        if (s1_valid) begin
          rsp_data <= (s1_func == FUNC_TANH) ? tanh_y : sig_y;
          rsp_id   <= s1_id;
        end
      end
      if (s1_open)
        s1_valid <= xfer;
      if (xfer) begin
        s1_data <= req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        s1_func <= req_func[gnt_idx];
        s1_id   <= gnt_idx;
        ptr     <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_act_lut_scheduler.sv
// Directed bench for act_lut_scheduler: arbitration, latency,
// backpressure, reset and a full-range golden LUT sweep.
module tb_act_lut_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_data;
  logic [3:0]  req_func;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  act_lut_scheduler #(.NREQ(4), .DATA_WIDTH(8), .FRACT_WIDTH(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_func  (req_func),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  // Real-valued reference curve, x >= 0.
  function automatic real plan(real x);
    if (x >= 5.0)   return 1.0;
    if (x >= 2.375) return 0.03125 * x + 0.84375;
    if (x >= 1.0)   return 0.125 * x + 0.625;
    return 0.25 * x + 0.5;
  endfunction

  function automatic logic [7:0] sig_model(logic [7:0] op);
    int  v;
    int  s;
    real ax;
    v  = int'($signed(op));
    ax = real'(v < 0 ? -v : v) / 32.0;
    s  = int'($floor(32.0 * plan(ax)));
    return op[7] ? 8'(32 - s) : 8'(s);
  endfunction

  function automatic logic [7:0] tanh_model(logic [7:0] op);
    int  v;
    int  s;
    int  t;
    real ax;
    v  = int'($signed(op));
    ax = real'(v < 0 ? -v : v) / 32.0;
    s  = int'($floor(32.0 * plan(2.0 * ax)));
    t  = 2 * s - 32;
    return op[7] ? 8'(-t) : 8'(t);
  endfunction

  function automatic logic [7:0] golden(logic [7:0] op, logic f);
    return f ? tanh_model(op) : sig_model(op);
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 4'hF;
    req_data = 32'h0;
    req_func = 4'h0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (req_ready !== 4'h0) begin
      fails++;
      $display("FAIL reset_ready got %b want 0000", req_ready);
    end
    tests++;
    if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_id !== 2'd0) begin
      fails++;
      $display("FAIL reset_rsp got v=%b d=%h id=%0d want 0/00/0",
               rsp_valid, rsp_data, rsp_id);
    end
    rst = 1'b0;
    req_valid = 4'h0;
  endtask

  task automatic test_sigmoid_zero;
    @(negedge clk);
    req_valid = 4'b0001;
    req_data[7:0] = 8'h00;
    req_func[0] = 1'b0;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL sig0_grant got %b want 0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'h0;
    tests++;
    if (rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL sig0_early got v=%b want 0", rsp_valid);
    end
    @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h10 || rsp_id !== 2'd0) begin
      fails++;
      $display("FAIL sig0_rsp got v=%b d=%h id=%0d want 1/10/0",
               rsp_valid, rsp_data, rsp_id);
    end
  endtask

  task automatic test_tanh_zero;
    @(negedge clk);
    req_valid = 4'b0100;
    req_data[23:16] = 8'h00;
    req_func[2] = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0100) begin
      fails++;
      $display("FAIL tanh0_grant got %b want 0100", req_ready);
    end
    @(negedge clk);
    req_valid = 4'h0;
    @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h00 || rsp_id !== 2'd2) begin
      fails++;
      $display("FAIL tanh0_rsp got v=%b d=%h id=%0d want 1/00/2",
               rsp_valid, rsp_data, rsp_id);
    end
  endtask

  task automatic test_round_robin;
    logic [7:0] d;
    int g;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_data[8*i +: 8] = 8'(8'h10 * i + 8'h08);
      req_func[i] = i[0];
    end
    req_valid = 4'hF;
    for (int c = 0; c < 13; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 10) req_valid = 4'h0;
      #1;
      if (c < 10) begin
        tests++;
        if (req_ready !== 4'(1 << (c % 4))) begin
          fails++;
          $display("FAIL rr_grant c=%0d got %b want %b",
                   c, req_ready, 4'(1 << (c % 4)));
        end
      end
      if (c >= 2 && c < 12) begin
        g = (c - 2) % 4;
        d = 8'(8'h10 * g + 8'h08);
        tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'(g) ||
            rsp_data !== golden(d, g[0])) begin
          fails++;
          $display("FAIL rr_rsp c=%0d got v=%b id=%0d d=%h want 1/%0d/%h",
                   c, rsp_valid, rsp_id, rsp_data, g, golden(d, g[0]));
        end
      end
      if (c == 12) begin
        tests++;
        if (rsp_valid !== 1'b0) begin
          fails++;
          $display("FAIL rr_drain got v=%b want 0", rsp_valid);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int   nsent = 0;
    int   nrx = 0;
    logic xfer = 1'b0;
    logic [7:0] e;
    for (int cyc = 0; cyc < 600 && nrx < 256; cyc++) begin
      @(negedge clk);
      if (xfer) nsent++;
      req_valid = (nsent < 256) ? 4'b0010 : 4'b0000;
      req_data[15:8] = 8'(nsent);
      req_func[1] = nsent[0];
      rsp_ready = !(cyc >= 10 && cyc <= 12);
      #1;
      e = golden(8'(nrx), nrx[0]);
      if (rsp_valid && rsp_ready) begin
        tests++;
        if (rsp_id !== 2'd1 || rsp_data !== e) begin
          fails++;
          $display("FAIL bp_rsp n=%0d got id=%0d d=%h want 1/%h",
                   nrx, rsp_id, rsp_data, e);
        end
        nrx++;
      end
      if (!rsp_ready) begin
        tests++;
        if (rsp_valid !== 1'b1 || rsp_data !== e || rsp_id !== 2'd1) begin
          fails++;
          $display("FAIL bp_hold cyc=%0d got v=%b d=%h id=%0d want 1/%h/1",
                   cyc, rsp_valid, rsp_data, rsp_id, e);
        end
        tests++;
        if (req_ready !== 4'h0) begin
          fails++;
          $display("FAIL bp_ready cyc=%0d got %b want 0000", cyc, req_ready);
        end
      end
      xfer = req_valid[1] & req_ready[1];
    end
    tests++;
    if (nrx != 256) begin
      fails++;
      $display("FAIL bp_count got %0d want 256", nrx);
    end
    req_valid = 4'h0;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    req_valid = 4'b0010;
    req_data[15:8] = 8'h33;
    req_func[1] = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if (rsp_valid !== 1'b1 || req_ready !== 4'h0) begin
      fails++;
      $display("FAIL rm_full got v=%b rdy=%b want 1/0000",
               rsp_valid, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b1010;
    req_data[15:8] = 8'h20;
    req_func[1] = 1'b0;
    req_data[31:24] = 8'hE0;
    req_func[3] = 1'b1;
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0010) begin
      fails++;
      $display("FAIL rm_after got v=%b rdy=%b want 0/0010",
               rsp_valid, req_ready);
    end
    @(negedge clk);
    req_valid = 4'b1000;
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin
      fails++;
      $display("FAIL rm_stale got v=%b rdy=%b want 0/1000",
               rsp_valid, req_ready);
    end
    @(negedge clk);
    req_valid = 4'h0;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 8'h18) begin
      fails++;
      $display("FAIL rm_rsp1 got v=%b id=%0d d=%h want 1/1/18",
               rsp_valid, rsp_id, rsp_data);
    end
    @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 8'hE8) begin
      fails++;
      $display("FAIL rm_rsp3 got v=%b id=%0d d=%h want 1/3/e8",
               rsp_valid, rsp_id, rsp_data);
    end
    @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL rm_end got v=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_sparse;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b1000;
    req_data[31:24] = 8'h40;
    req_func[3] = 1'b0;
    #1;
    tests++;
    if (req_ready !== 4'b1000) begin
      fails++;
      $display("FAIL sp_grant3 got %b want 1000", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b1001;
    req_data[7:0] = 8'h00;
    req_func[0] = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL sp_wrap got %b want 0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'h0;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 8'h1C) begin
      fails++;
      $display("FAIL sp_rsp3 got v=%b id=%0d d=%h want 1/3/1c",
               rsp_valid, rsp_id, rsp_data);
    end
    @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 8'h00) begin
      fails++;
      $display("FAIL sp_rsp0 got v=%b id=%0d d=%h want 1/0/00",
               rsp_valid, rsp_id, rsp_data);
    end
  endtask

  initial begin
    test_reset();
    test_sigmoid_zero();
    test_tanh_zero();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_sparse();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/act_lut_scheduler.md
Name: act_lut_scheduler

Overview:
Shares one sigmoid LUT and one tanh LUT between NREQ requesters, e.g. the gate units of a GRU/LSTM cell. It arbitrates per-cycle lookup requests round-robin and pipelines the selected operand through the chosen LUT. It returns each result tagged with the requester index. It sits between the gate datapaths and the combinational sigmoid_lut/tanh_lut instances.

Parameters:
NREQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, operand/result width, signed fixed point
FRACT_WIDTH, 5, fractional bits of operand and result
AW, 8, LUT address width; must equal DATA_WIDTH
DW, 8, LUT data width; must equal DATA_WIDTH

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept (one-hot or zero)
req_data  in  NREQ*DATA_WIDTH  operands, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
req_func  in  NREQ  function select per requester: 0 = sigmoid, 1 = tanh
rsp_valid  out  1  result valid
rsp_ready  in  1  result consumer ready
rsp_data  out  DATA_WIDTH  LUT result
rsp_id  out  max(1,$clog2(NREQ))  index of requester that issued the result

Behaviour:
- Reset (rst=1 at an edge):
  - rsp_valid=0, rsp_data=0, rsp_id=0.
  - Both pipeline stages are emptied.
  - Round-robin pointer is set to 0, so requester 0 has highest priority.
  - req_ready is 0 while rst is high.
  - Reset mid-operation discards all in-flight lookups; no response is produced for them.
- Pipeline:
  - S1 holds the operand, function and id; it is valid/empty.
  - S2 holds rsp_data and rsp_id; its valid is rsp_valid.
  - The LUTs are combinational from S1. S2 registers the mux of sigmoid/tanh outputs selected by the S1 function.
- Stall and advance:
  - stall = rsp_valid & ~rsp_ready.
  - S2 loads from S1 when ~stall.
  - S1 can accept when S1 is empty or S1 advances (~stall).
- Arbitration (combinational):
  - Among asserted req_valid, grant the first index at or after the pointer, wrapping modulo NREQ.
  - req_ready[g] = 1 only for the granted g, and only when S1 can accept. All other bits are 0.
  - req_ready depends on req_valid combinationally. Requesters must not make req_valid depend on req_ready.
- Handshake: a transfer occurs on req_valid[i] & req_ready[i] at an edge.
  - On transfer, S1 captures req_data[i], req_func[i] and id=i.
  - The pointer becomes (i+1) mod NREQ.
  - With no transfer, the pointer holds.
- Latency and throughput:
  - A transfer at edge k gives rsp_valid high after edge k+1 when there is no stall.
  - Throughput is one result per cycle.
  - Results leave in acceptance order.
- Backpressure:
  - While stalled, rsp_data and rsp_id are held stable and S2 does not change.
  - If S1 is also full, all req_ready bits are 0.
  - No lookup is lost or duplicated.
- Requester obligation: once req_valid is asserted, a requester keeps req_valid, req_data and req_func stable until accepted.
- Arithmetic:
  - The LUT address is the raw two's-complement operand bits (no offset).
  - The result is the LUT word unchanged.
  - Width rule: AW=DW=DATA_WIDTH.
- Edge cases:
  - A single requester gets back-to-back grants.
  - Pointer wrap: after requester NREQ-1 is granted, the pointer goes to 0.
  - Simultaneous accept and stall release in the same cycle is legal; S1 and S2 both advance.

Decomposition:
- Package act_pkg:
  - FUNC_SIGMOID=1'b0, FUNC_TANH=1'b1.
  - Default DATA_WIDTH/FRACT_WIDTH localparams.
  - A function for requester id width.
- Sub-module rr_arbiter (NREQ): inputs req, pointer, enable; outputs one-hot grant and encoded index. Reusable for other shared gate resources.
- sigmoid_lut and tanh_lut are instantiated unchanged, one of each.

Test Plan:
- Sigmoid at zero: requester 0 sends sigmoid, data 8'h00 → rsp_valid 2 edges later, rsp_data=8'h10 (0.5 in Q2.5), rsp_id=0.
- Tanh at zero: requester 2 sends tanh, data 8'h00 → rsp_data=8'h00, rsp_id=2.
- Round-robin: all 4 requesters hold req_valid continuously, rsp_ready=1.
  - Grant order is 0,1,2,3,0,1…, one transfer per cycle.
  - rsp_id sequence matches the grant order.
- Backpressure: stream from requester 1 and drop rsp_ready for 3 cycles.
  - rsp_data/rsp_id hold stable.
  - req_ready goes 0 after S1 fills.
  - After release, all 256 results for operands 0..255 arrive in order and match a golden LUT model.
- Reset mid-operation: assert rst for 1 cycle with both stages full.
  - rsp_valid=0 next cycle.
  - Pointer returns to 0: with requesters 1 and 3 valid, first grant goes to 1.
  - No stale response appears.
- Sparse requests: only requester 3 valid, pointer at 0 → granted immediately, pointer becomes 0 (wrap).
